// File: rtl/spi_rr_arbiter_if.sv
// rtl/spi_rr_arbiter_if.sv - requester and SPI-master side signals of spi_rr_arbiter
interface spi_rr_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int F_SIZE = 8
);
  logic [N_REQ-1:0]        req_i;
  logic [N_REQ*F_SIZE-1:0] tx_data_i;
  logic [N_REQ-1:0]        gnt_o;
  logic [N_REQ-1:0]        done_o;
  logic [F_SIZE-1:0]       rx_data_o;
  logic                    err_o;
  logic                    m_start_o;
  logic [F_SIZE-1:0]       m_tx_data_o;
  logic                    m_cs_i;
  logic [F_SIZE-1:0]       m_rx_data_i;

  // Arbiter view: takes requests and master status, drives grants and master start.
  modport slave (
    input  req_i, tx_data_i, m_cs_i, m_rx_data_i,
    output gnt_o, done_o, rx_data_o, err_o, m_start_o, m_tx_data_o
  );

  // Environment view: requesters plus the SPI master.
  modport master (
    output req_i, tx_data_i, m_cs_i, m_rx_data_i,
    input  gnt_o, done_o, rx_data_o, err_o, m_start_o, m_tx_data_o
  );
endinterface

// File: rtl/spi_rr_arbiter.sv
// rtl/spi_rr_arbiter.sv - round-robin scheduler sharing one SPI master; SPI_ARB_TIMEOUT_EN adds a per-phase abort
module spi_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int F_SIZE  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst,
  spi_rr_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [F_SIZE-1:0] rx_q, rx_d;
  logic [F_SIZE-1:0] m_tx_q, m_tx_d;
  logic              m_start_q, m_start_d;
  logic              cs_meta_q, cs_meta_d;
  logic              cs_s_q, cs_s_d;

  logic              pick_found;
  logic [PW-1:0]     pick_idx;
  logic [PW:0]       cand;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          timeout_hit;

  // The abort fires on the cycle the counter would step onto TIMEOUT.
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  // Round-robin pick: first requester at or above ptr, wrapping to index 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(i);
      if (cand >= (PW+1)'(N_REQ)) begin
        cand = cand - (PW+1)'(N_REQ);
      end
      if (!pick_found && bus.req_i[cand[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
  end

  // Next-state and next-output logic; every output is registered.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rx_d      = rx_q;
    m_tx_d    = m_tx_q;
    m_start_d = 1'b0;
    cs_meta_d = bus.m_cs_i;
    cs_s_d    = cs_meta_q;
`ifdef SPI_ARB_TIMEOUT_EN
    err_d     = 1'b0;
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          win_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          m_tx_d          = bus.tx_data_i[int'(pick_idx)*F_SIZE +: F_SIZE];
          m_start_d       = 1'b1;
          state_d         = S_START;
        end
      end
      S_START: begin
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!cs_s_q) begin
`ifdef SPI_ARB_TIMEOUT_EN
          cnt_d = '0;
`endif
          state_d = S_WAIT_HIGH;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          rx_d          = '0;
          done_d[win_q] = 1'b1;
          err_d         = 1'b1;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_WAIT_HIGH: begin
        if (cs_s_q) begin
          rx_d          = bus.m_rx_data_i;
          done_d[win_q] = 1'b1;
          state_d       = S_DONE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          rx_d          = '0;
          done_d[win_q] = 1'b1;
          err_d         = 1'b1;
          state_d       = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      S_DONE: begin
        // gnt stays up through the done cycle so the requester sees both together.
        gnt_d = '0;
        if (win_q == PW'(N_REQ - 1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = win_q + PW'(1);
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, pointer, synchronizer and output registers; reset drops everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      win_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rx_q      <= '0;
      m_tx_q    <= '0;
      m_start_q <= 1'b0;
      cs_meta_q <= 1'b1;
      cs_s_q    <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rx_q      <= rx_d;
      m_tx_q    <= m_tx_d;
      m_start_q <= m_start_d;
      cs_meta_q <= cs_meta_d;
      cs_s_q    <= cs_s_d;
`ifdef SPI_ARB_TIMEOUT_EN
      err_q     <= err_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.done_o      = done_q;
  assign bus.rx_data_o   = rx_q;
  assign bus.m_start_o   = m_start_q;
  assign bus.m_tx_data_o = m_tx_q;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.err_o       = err_q;
`else
  assign bus.err_o       = 1'b0;
`endif
endmodule

// File: tb/tb_spi_rr_arbiter.sv
// tb/tb_spi_rr_arbiter.sv - self-checking bench for spi_rr_arbiter
module tb_spi_rr_arbiter;
  localparam int N    = 4;
  localparam int F    = 8;
  localparam int TOUT = 16;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int HI_DLY = 10;
  localparam bit TO_ON  = 1'b1;
`else
  localparam int HI_DLY = 20;
  localparam bit TO_ON  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_rr_arbiter_if #(.N_REQ(N), .F_SIZE(F)) bus ();

  spi_rr_arbiter #(.N_REQ(N), .F_SIZE(F), .TIMEOUT(TOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] frames [4] = '{8'h11, 8'hA5, 8'h5A, 8'hC3};
  int order [5] = '{0, 1, 2, 3, 0};
  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit slave_en = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int rr(input int p, input logic [3:0] r);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  // Model state: one outstanding transaction described by its event times.
  bit         m_busy = 1'b0;
  bit         m_to = 1'b0;
  bit         m_done_now = 1'b0;
  int         m_owner = 0;
  int         m_tg = 0;
  int         m_low = -1;
  int         m_td = -1;
  int         m_ptr = 0;
  logic [7:0] m_tx = 8'h00;
  logic [7:0] m_rx = 8'h00;
  logic       m_cs1 = 1'b1;
  logic       m_cs2 = 1'b1;
  logic [3:0] e_gnt, e_done;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        m_busy = 1'b0; m_ptr = 0; m_tx = 8'h00; m_rx = 8'h00;
        m_cs1 = 1'b1; m_cs2 = 1'b1; m_td = -1;
      end else begin
        e_gnt  = (m_busy && cyc >= m_tg) ? 4'(1 << m_owner) : 4'b0;
        e_done = (m_busy && cyc == m_td) ? 4'(1 << m_owner) : 4'b0;
        chk("gnt", 32'(bus.gnt_o), 32'(e_gnt));
        chk("gnt_onehot", 32'($countones(bus.gnt_o) <= 1), 32'd1);
        chk("m_start", 32'(bus.m_start_o), 32'(m_busy && cyc == m_tg));
        chk("m_tx_data", 32'(bus.m_tx_data_o), 32'(m_tx));
        chk("done", 32'(bus.done_o), 32'(e_done));
        chk("rx_data", 32'(bus.rx_data_o), 32'(m_rx));
        chk("err", 32'(bus.err_o), 32'(m_busy && cyc == m_td && m_to));
        m_done_now = m_busy && (cyc == m_td);
        if (m_done_now) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % N;
        end
        if (m_busy && m_td < 0) begin
          if (m_low < 0) begin
            if (cyc >= m_tg + 1) begin
              if (!m_cs2) m_low = cyc;
              else if (TO_ON && cyc == m_tg + TOUT) begin
                m_td = cyc + 1; m_to = 1'b1; m_rx = 8'h00;
              end
            end
          end else if (cyc > m_low) begin
            if (m_cs2) begin
              m_td = cyc + 1; m_rx = bus.m_rx_data_i;
            end else if (TO_ON && cyc == m_low + TOUT) begin
              m_td = cyc + 1; m_to = 1'b1; m_rx = 8'h00;
            end
          end
        end else if (!m_busy && !m_done_now && bus.req_i != 4'b0) begin
          m_owner = rr(m_ptr, bus.req_i);
          m_busy  = 1'b1;
          m_tg    = cyc + 1;
          m_low   = -1;
          m_td    = -1;
          m_to    = 1'b0;
          m_tx    = frames[m_owner];
        end
        m_cs2 = m_cs1;
        m_cs1 = bus.m_cs_i;
      end
    end
  end

  // Bench SPI master: CS low 5 cycles after start, high HI_DLY cycles later.
  initial begin
    int  rcnt;
    bit  act;
    rcnt = 0;
    act  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        act = 1'b0;
        bus.m_cs_i = 1'b1;
      end else if (act) begin
        rcnt++;
        if (rcnt == 5) bus.m_cs_i = 1'b0;
        if (rcnt == 5 + HI_DLY) begin
          bus.m_rx_data_i = bus.m_tx_data_o ^ 8'h99;
          bus.m_cs_i = 1'b1;
          act = 1'b0;
        end
      end else if (slave_en && bus.m_start_o) begin
        act  = 1'b1;
        rcnt = 0;
      end
    end
  end

  task automatic wait_gnt(output logic [3:0] g, output longint t);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.gnt_o == 4'b0 && k < 200);
    if (bus.gnt_o == 4'b0) begin
      n_vec++; n_fail++;
      $display("FAIL gnt_wait: actual=no grant required=grant within 200 cycles");
    end
    g = bus.gnt_o;
    t = $time;
  endtask

  task automatic wait_done(output logic [3:0] d, output longint t);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.done_o == 4'b0 && k < 200);
    if (bus.done_o == 4'b0) begin
      n_vec++; n_fail++;
      $display("FAIL done_wait: actual=no done required=done within 200 cycles");
    end
    d = bus.done_o;
    t = $time;
  endtask

  task automatic set_req(input logic [3:0] r);
    @(posedge clk);
    #1;
    bus.req_i = r;
  endtask

  initial begin
    logic [3:0] g, d;
    longint tg, td;
    bus.req_i       = 4'b0;
    bus.tx_data_i   = {frames[3], frames[2], frames[1], frames[0]};
    bus.m_cs_i      = 1'b1;
    bus.m_rx_data_i = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_rx", 32'(bus.rx_data_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_start", 32'(bus.m_start_o), 32'd0);
    chk("rst_tx", 32'(bus.m_tx_data_o), 32'd0);
    rst = 1'b1;

    // single request from requester 1
    set_req(4'b0010);
    wait_gnt(g, tg);
    chk("t1_gnt", 32'(g), 32'h2);
    chk("t1_start", 32'(bus.m_start_o), 32'd1);
    chk("t1_tx", 32'(bus.m_tx_data_o), 32'hA5);
    wait_done(d, td);
    chk("t1_done", 32'(d), 32'h2);
    chk("t1_rx", 32'(bus.rx_data_o), 32'h3C);
    chk("t1_err", 32'(bus.err_o), 32'd0);
    chk("t1_latency", 32'((td - tg) / 10), 32'(8 + HI_DLY));
    set_req(4'b0000);

    // pointer back to 0, then full contention
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    bus.req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(g, tg);
      chk("rr_order", 32'(g), 32'(1 << order[i]));
      wait_done(d, td);
      chk("rr_done", 32'(d), 32'(1 << order[i]));
    end
    set_req(4'b1000);
    wait_gnt(g, tg);
    chk("t3_gnt", 32'(g), 32'h8);
    wait_done(d, td);
    set_req(4'b0101);
    wait_gnt(g, tg);
    chk("wrap_gnt", 32'(g), 32'h1);
    wait_done(d, td);
    chk("wrap_done", 32'(d), 32'h1);

    // requester 2 drops its request while the frame is in flight
    set_req(4'b0100);
    wait_gnt(g, tg);
    chk("drop_gnt", 32'(g), 32'h4);
    repeat (3) @(posedge clk);
    #1; bus.req_i = 4'b0000;
    wait_done(d, td);
    chk("drop_done", 32'(d), 32'h4);
    chk("drop_rx", 32'(bus.rx_data_o), 32'(8'h5A ^ 8'h99));

    // reset in the middle of a frame (ptr is 3, so requester 0 wins by wrap)
    set_req(4'b0001);
    wait_gnt(g, tg);
    chk("mid_gnt", 32'(g), 32'h1);
    repeat (15) @(negedge clk);
    #3;
    rst = 1'b0;
    bus.req_i = 4'b0000;
    #1;
    chk("arst_gnt", 32'(bus.gnt_o), 32'd0);
    chk("arst_done", 32'(bus.done_o), 32'd0);
    chk("arst_rx", 32'(bus.rx_data_o), 32'd0);
    chk("arst_err", 32'(bus.err_o), 32'd0);
    chk("arst_start", 32'(bus.m_start_o), 32'd0);
    chk("arst_tx", 32'(bus.m_tx_data_o), 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    bus.req_i = 4'b1000;
    wait_gnt(g, tg);
    chk("post_rst_gnt", 32'(g), 32'h8);
    wait_done(d, td);
    chk("post_rst_done", 32'(d), 32'h8);
    set_req(4'b0000);

`ifdef SPI_ARB_TIMEOUT_EN
    // silent master: abort after TOUT cycles in WAIT_LOW
    slave_en = 1'b0;
    set_req(4'b0010);
    wait_gnt(g, tg);
    chk("to_gnt", 32'(g), 32'h2);
    wait_done(d, td);
    chk("to_done", 32'(d), 32'h2);
    chk("to_err", 32'(bus.err_o), 32'd1);
    chk("to_rx", 32'(bus.rx_data_o), 32'd0);
    chk("to_latency", 32'((td - tg) / 10), 32'd17);
    set_req(4'b0000);
    slave_en = 1'b1;
`endif

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=still running required=finished by 200000");
    $fatal(1);
  end
endmodule
